// File: rtl/wd_service_gen.sv
// Watchdog service-window generator: opens a servicing window, issues one
// service pulse when the software task completes, and escalates repeated failed checks.
module wd_service_gen #(
  parameter int TMO      = 16,
  parameter int GAP      = 8,
  parameter int MAX_FAIL = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_task_done,
  input  logic       i_clr,
  input  logic       i_wdfail,
  input  logic [2:0] i_flstat,
  output logic       o_swstat,
  output logic       o_wdsrvc,
  output logic       o_fwovr,
  output logic [1:0] o_failcnt,
  output logic [2:0] o_lastfl
);

  // state    | meaning
  // IDLE     | waiting for EN
  // OPEN     | window open, waiting for TASK_DONE or timeout
  // SERVE    | one-cycle service pulse
  // HOLD     | window held one more cycle after the pulse
  // GAP      | window closed, settling before the fail check
  // CHECK    | sample the fail detector
  // OVERRIDE | firmware override requested until CLR
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_SERVE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_OVR   = 3'd6;

  localparam logic [7:0] TMO_M1     = 8'(TMO - 1);
  localparam logic [7:0] GAP_M1     = 8'(GAP - 1);
  localparam logic [1:0] MAX_FAIL_L = 2'(MAX_FAIL);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_swstat;
  logic       r_wdsrvc;
  logic       r_fwovr;
  logic [1:0] r_failcnt;
  logic [2:0] r_lastfl;

  logic [2:0] w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] w_failcnt_inc;

  assign w_failcnt_inc = (r_failcnt == 2'd3) ? 2'd3 : r_failcnt + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 8'd0;
        if (i_en) w_state_nxt = S_OPEN;
      end
      S_OPEN: begin
        // TASK_DONE takes priority over the timeout on the same cycle
        if (i_task_done) begin
          w_state_nxt = S_SERVE;
        end else if (r_cnt == TMO_M1) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_SERVE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = 8'd0;
      end
      S_GAP: begin
        if (r_cnt == GAP_M1) w_state_nxt = S_CHECK;
        else                 w_cnt_nxt   = r_cnt + 8'd1;
      end
      S_CHECK: begin
        if (i_wdfail && !i_clr && (w_failcnt_inc >= MAX_FAIL_L)) w_state_nxt = S_OVR;
        else                                                     w_state_nxt = S_IDLE;
      end
      S_OVR: begin
        if (i_clr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_swstat  <= 1'b0;
      r_wdsrvc  <= 1'b0;
      r_fwovr   <= 1'b0;
      r_failcnt <= 2'd0;
      r_lastfl  <= 3'b100;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      // outputs decode the next state so they line up with the state register
      r_swstat <= (w_state_nxt == S_OPEN) || (w_state_nxt == S_SERVE) || (w_state_nxt == S_HOLD);
      r_wdsrvc <= (w_state_nxt == S_SERVE);
      r_fwovr  <= (w_state_nxt == S_OVR);
      if (i_clr)                   r_failcnt <= 2'd0;
      else if (r_state == S_CHECK) r_failcnt <= i_wdfail ? w_failcnt_inc : 2'd0;
      if ((r_state == S_CHECK) && i_wdfail) r_lastfl <= i_flstat;
    end
  end

  assign o_swstat  = r_swstat;
  assign o_wdsrvc  = r_wdsrvc;
  assign o_fwovr   = r_fwovr;
  assign o_failcnt = r_failcnt;
  assign o_lastfl  = r_lastfl;

endmodule

// File: tb/tb_wd_service_gen.sv
// Directed bench for wd_service_gen: stimulus pushes expected windows into a
// scoreboard queue, a negedge monitor pops one per closed window.
module tb_wd_service_gen;

  localparam int TMO = 16;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       task_done = 1'b0;
  logic       clr = 1'b0;
  logic       wdfail = 1'b0;
  logic [2:0] flstat = 3'b000;
  logic       swstat, wdsrvc, fwovr;
  logic [1:0] failcnt;
  logic [2:0] lastfl;

  typedef struct {
    int len;
    int pulses;
    int pos;
  } win_t;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   proto_err = 0;

  wd_service_gen #(.TMO(TMO), .GAP(GAP), .MAX_FAIL(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_task_done(task_done),
    .i_clr      (clr),
    .i_wdfail   (wdfail),
    .i_flstat   (flstat),
    .o_swstat   (swstat),
    .o_wdsrvc   (wdsrvc),
    .o_fwovr    (fwovr),
    .o_failcnt  (failcnt),
    .o_lastfl   (lastfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input int e_cnt, input int e_fl, input int e_ovr);
    chk({tag, "_failcnt"}, int'(failcnt), e_cnt);
    chk({tag, "_lastfl"}, int'(lastfl), e_fl);
    chk({tag, "_fwovr"}, int'(fwovr), e_ovr);
  endtask

  // One service cycle from IDLE; td_at < 0 means the window times out.
  task automatic run_cycle(input int td_at, input bit fail, input logic [2:0] fl, input bit clr_chk);
    int open_len;
    win_t w;
    open_len = (td_at >= 0) ? td_at + 1 : TMO;
    w.len    = (td_at >= 0) ? td_at + 3 : TMO;
    w.pulses = (td_at >= 0) ? 1 : 0;
    w.pos    = td_at + 2;
    exp_q.push_back(w);
    en = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < open_len; k++) begin
      task_done = (k == td_at);
      step();
    end
    task_done = 1'b0;
    if (td_at >= 0) begin
      step();
      step();
    end
    repeat (GAP) step();
    wdfail = fail;
    flstat = fl;
    clr    = clr_chk;
    step();
    wdfail = 1'b0;
    flstat = 3'b000;
    clr    = 1'b0;
  endtask

  initial begin : monitor
    bit prev_sw;
    int len, pc, pos;
    win_t w;
    prev_sw = 1'b0;
    len = 0; pc = 0; pos = 0;
    forever begin
      @(negedge clk);
      if (wdsrvc && !swstat) begin
        proto_err++;
        $display("FAIL protocol_pulse_outside_window at %0t", $time);
      end
      if (swstat) begin
        len++;
        if (wdsrvc) begin
          pc++;
          pos = len;
        end
      end else if (prev_sw) begin
        if (pc > 1) begin
          proto_err++;
          $display("FAIL protocol_multi_pulse: got %0d pulses expected at most 1", pc);
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL window_unexpected: got len %0d expected no window", len);
        end else begin
          w = exp_q.pop_front();
          chk("window_len", len, w.len);
          chk("window_pulses", pc, w.pulses);
          if (w.pulses > 0) chk("pulse_pos", pos, w.pos);
        end
        len = 0; pc = 0; pos = 0;
      end
      prev_sw = swstat;
    end
  end

  initial begin : stim
    win_t w;
    repeat (2) step();
    chk("rst_swstat", int'(swstat), 0);
    chk("rst_wdsrvc", int'(wdsrvc), 0);
    status("rst", 0, 3'b100, 0);
    rst_n = 1'b1;
    step();

    run_cycle(3, 1'b0, 3'b000, 1'b0);
    status("nominal", 0, 3'b100, 0);
    run_cycle(-1, 1'b1, 3'b011, 1'b0);
    status("timeout", 1, 3'b011, 0);
    run_cycle(3, 1'b0, 3'b000, 1'b0);
    status("pass_clears", 0, 3'b011, 0);

    run_cycle(-1, 1'b1, 3'b101, 1'b0);
    status("esc1", 1, 3'b101, 0);
    run_cycle(0, 1'b1, 3'b110, 1'b0);
    status("esc2", 2, 3'b110, 0);
    run_cycle(5, 1'b1, 3'b111, 1'b0);
    status("esc3", 3, 3'b111, 1);
    en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    chk("ovr_no_window", int'(swstat), 0);
    chk("ovr_sticky", int'(fwovr), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    status("ovr_clr", 0, 3'b111, 0);

    run_cycle(15, 1'b1, 3'b110, 1'b0);
    status("race_td", 1, 3'b110, 0);
    run_cycle(-1, 1'b1, 3'b101, 1'b0);
    status("race_pre", 2, 3'b101, 0);
    run_cycle(3, 1'b1, 3'b010, 1'b1);
    status("race_clr", 0, 3'b010, 0);

    run_cycle(-1, 1'b1, 3'b001, 1'b0);
    status("idle_pre", 1, 3'b001, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    status("idle_clr", 0, 3'b001, 0);

    run_cycle(-1, 1'b1, 3'b001, 1'b0);
    w.len = 4; w.pulses = 0; w.pos = 0;
    exp_q.push_back(w);
    en = 1'b1;
    step();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      task_done = (k == 3);
      step();
    end
    task_done = 1'b0;
    chk("serve_pulse", int'(wdsrvc), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_wdsrvc", int'(wdsrvc), 0);
    chk("async_rst_swstat", int'(swstat), 0);
    status("async_rst", 0, 3'b100, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_cycle(3, 1'b0, 3'b000, 1'b0);
    status("recover", 0, 3'b100, 0);

    repeat (3) step();
    chk("windows_outstanding", exp_q.size(), 0);
    chk("protocol_errors", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
